// File: rtl/display_page_scheduler.sv
// Time-shares the LED-matrix driver between status pages: round-robin rotation on the 1 Hz tick, alert pages pre-empt and blink.
// Registered outputs with 1-cycle latency from page_data; no backpressure, and the driver samples frame_out whenever frame_update pulses.
module display_page_scheduler #(
  parameter  int N_PAGES     = 2,
  parameter  int DWELL_TICKS = 2,
  localparam int PSW         = (N_PAGES > 1) ? $clog2(N_PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic [35*N_PAGES-1:0] page_data,
  input  logic [N_PAGES-1:0]    page_valid,
  input  logic [N_PAGES-1:0]    alert_req,
  output logic [34:0]           frame_out,
  output logic [PSW-1:0]        page_sel,
  output logic                  alert_active,
  output logic                  frame_update
);

  typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

  state_t         state_q, state_d;
  logic [PSW-1:0] sel_q, sel_d, ret_q, ret_d;
  logic [3:0]     dwell_q, dwell_d;
  logic           phase_q, phase_d;
  logic [2:0]     sync_q;
  logic           tick_p_q;
  logic [34:0]    frame_q, frame_d;
  logic           alert_q, alert_d, upd_q, upd_d;

  logic [N_PAGES-1:0] eff;
  logic [PSW-1:0]     winner, lowest;

  // First valid index strictly after cur, wrapping; returns cur if it is the only valid page.
  function automatic logic [PSW-1:0] next_valid(input logic [PSW-1:0] cur,
                                                input logic [N_PAGES-1:0] vld);
    logic [PSW-1:0] res;
    logic           found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= N_PAGES; k++) begin
      int idx;
      idx = (int'(cur) + k) % N_PAGES;
      if (!found && vld[idx]) begin
        res   = PSW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign eff    = alert_req & page_valid;
  assign lowest = next_valid(PSW'(N_PAGES - 1), page_valid);

  always_comb begin
    winner = '0;
    for (int k = N_PAGES - 1; k >= 0; k--) begin
      if (eff[k]) winner = PSW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ret_d   = ret_q;
    dwell_d = dwell_q;
    phase_d = 1'b1;
    if (page_valid == '0) begin
      state_d = IDLE;
      sel_d   = '0;
      dwell_d = '0;
    end else if (eff != '0) begin
      state_d = ALERT;
      sel_d   = winner;
      dwell_d = '0;
      if (state_q != ALERT) begin
        ret_d = (state_q == SHOW) ? sel_q : lowest;
      end else if (winner == sel_q) begin
        phase_d = tick_p_q ? ~phase_q : phase_q;
      end
    end else begin
      state_d = SHOW;
      case (state_q)
        IDLE: begin
          sel_d   = lowest;
          dwell_d = '0;
        end
        ALERT: begin
          sel_d   = page_valid[ret_q] ? ret_q : next_valid(ret_q, page_valid);
          dwell_d = '0;
        end
        default: begin
          if (!page_valid[sel_q]) begin
            sel_d   = next_valid(sel_q, page_valid);
            dwell_d = '0;
          end else if (tick_p_q) begin
            if (dwell_q == 4'(DWELL_TICKS - 1)) begin
              dwell_d = '0;
              sel_d   = next_valid(sel_q, page_valid);
            end else begin
              dwell_d = dwell_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    frame_d = '0;
    if (state_d == SHOW || (state_d == ALERT && phase_d)) begin
      frame_d = page_data[35*int'(sel_d) +: 35];
    end
    alert_d = (state_d == ALERT);
    upd_d   = (state_d != IDLE) &&
              ((sel_d != sel_q) || (phase_d != phase_q) || (state_d != state_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ret_q    <= '0;
      dwell_q  <= '0;
      phase_q  <= 1'b1;
      sync_q   <= '0;
      tick_p_q <= 1'b0;
      frame_q  <= '0;
      alert_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ret_q    <= ret_d;
      dwell_q  <= dwell_d;
      phase_q  <= phase_d;
      sync_q   <= {sync_q[1:0], tick_1hz};
      tick_p_q <= sync_q[1] & ~sync_q[2];
      frame_q  <= frame_d;
      alert_q  <= alert_d;
      upd_q    <= upd_d;
    end
  end

  assign frame_out    = frame_q;
  assign page_sel     = sel_q;
  assign alert_active = alert_q;
  assign frame_update = upd_q;

endmodule
